// File: rtl/cache_control.sv
// Sequencing FSM for the set-associative cache datapath: hit/miss handling,
// dirty-victim writeback, line fill and re-read, plus saturating event counters.
module cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             SIGHIT,
    input  logic             SIGDIRTY,
    output logic             LD_VALID,
    output logic             LD_DIRTY,
    output logic             LD_TAG,
    output logic             LD_DATA,
    output logic             LD_PLRU,
    output logic             DIRTYVAL,
    output logic             DIRTYWMUX,
    output logic             DATAWMUX,
    output logic             DATAMUX,
    output logic             PMADMUX,
    input  logic             clr_counters,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        REFILL    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;
    logic             req_s, hit_ev_s, miss_ev_s, wb_ev_s;

    // Clear wins over increment; increment stops at all-ones.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        if (clr)
            return '0;
        else if (inc && (cur != '1))
            return cur + CNT_W'(1);
        else
            return cur;
    endfunction

    assign req_s = mem_read | mem_write;

    // Next state, datapath controls and counter events.
    always_comb begin
        state_d   = state_q;
        mem_resp  = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        LD_VALID  = 1'b0;
        LD_DIRTY  = 1'b0;
        LD_TAG    = 1'b0;
        LD_DATA   = 1'b0;
        LD_PLRU   = 1'b0;
        DIRTYVAL  = 1'b0;
        DIRTYWMUX = 1'b0;
        DATAWMUX  = 1'b0;
        DATAMUX   = 1'b0;
        PMADMUX   = 1'b0;
        hit_ev_s  = 1'b0;
        miss_ev_s = 1'b0;
        wb_ev_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) state_d = COMPARE;
                else       state_d = IDLE;
            end
            COMPARE: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else if (SIGHIT) begin
                    mem_resp = 1'b1;
                    LD_PLRU  = 1'b1;
                    hit_ev_s = 1'b1;
                    // A simultaneous read+write is a write: merge CPU data into the hit way.
                    if (mem_write) begin
                        LD_DATA  = 1'b1;
                        LD_DIRTY = 1'b1;
                        DIRTYVAL = 1'b1;
                    end else begin
                        LD_DATA  = 1'b0;
                    end
                    state_d = IDLE;
                end else begin
                    miss_ev_s = 1'b1;
                    if (SIGDIRTY) state_d = WRITEBACK;
                    else          state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                PMADMUX    = 1'b1;
                if (pmem_resp) begin
                    LD_DIRTY  = 1'b1;
                    DIRTYWMUX = 1'b1;
                    wb_ev_s   = 1'b1;
                    state_d   = ALLOCATE;
                end else begin
                    state_d   = WRITEBACK;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    LD_DATA   = 1'b1;
                    DATAMUX   = 1'b1;
                    DATAWMUX  = 1'b1;
                    LD_TAG    = 1'b1;
                    LD_VALID  = 1'b1;
                    LD_DIRTY  = 1'b1;
                    DIRTYWMUX = 1'b1;
                    state_d   = REFILL;
                end else begin
                    state_d   = ALLOCATE;
                end
            end
            REFILL: begin
                if (req_s) state_d = COMPARE;
                else       state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hit_d  = cnt_next(hit_q, hit_ev_s, clr_counters);
        miss_d = cnt_next(miss_q, miss_ev_s, clr_counters);
        wb_d   = cnt_next(wb_q, wb_ev_s, clr_counters);
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hit_q   <= '0;
            miss_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wb_q    <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: per-cycle vector checks of the control
// outputs plus randomized transactions against a latency/counter model.
module tb_cache_control;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    logic rst, mem_read, mem_write, pmem_resp, SIGHIT, SIGDIRTY, clr_counters;
    logic mem_resp, pmem_read, pmem_write;
    logic LD_VALID, LD_DIRTY, LD_TAG, LD_DATA, LD_PLRU;
    logic DIRTYVAL, DIRTYWMUX, DATAWMUX, DATAMUX, PMADMUX;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    int tests = 0;
    int fails = 0;
    int m_hit, m_miss, m_wb;

    cache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .SIGHIT(SIGHIT), .SIGDIRTY(SIGDIRTY),
        .LD_VALID(LD_VALID), .LD_DIRTY(LD_DIRTY), .LD_TAG(LD_TAG),
        .LD_DATA(LD_DATA), .LD_PLRU(LD_PLRU),
        .DIRTYVAL(DIRTYVAL), .DIRTYWMUX(DIRTYWMUX), .DATAWMUX(DATAWMUX),
        .DATAMUX(DATAMUX), .PMADMUX(PMADMUX),
        .clr_counters(clr_counters),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Output vector order:
    // {mem_resp, LD_PLRU, LD_DATA, DATAMUX, DATAWMUX, LD_DIRTY, DIRTYVAL, DIRTYWMUX,
    //  LD_TAG, LD_VALID, pmem_read, pmem_write, PMADMUX}
    localparam logic [12:0] O_NONE   = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_RHIT   = 13'b1_1_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_WHIT   = 13'b1_1_1_0_0_1_1_0_0_0_0_0_0;
    localparam logic [12:0] O_ALLOC  = 13'b0_0_0_0_0_0_0_0_0_0_1_0_0;
    localparam logic [12:0] O_FILL   = 13'b0_0_1_1_1_1_0_1_1_1_1_0_0;
    localparam logic [12:0] O_WB     = 13'b0_0_0_0_0_0_0_0_0_0_0_1_1;
    localparam logic [12:0] O_WBDONE = 13'b0_0_0_0_0_1_0_1_0_0_0_1_1;

    typedef struct {
        logic        rd1, wr1, rd2, wr2, hit;
        logic [12:0] exp;
        string       nm;
    } vec_t;

    function automatic logic [12:0] outs();
        return {mem_resp, LD_PLRU, LD_DATA, DATAMUX, DATAWMUX, LD_DIRTY, DIRTYVAL,
                DIRTYWMUX, LD_TAG, LD_VALID, pmem_read, pmem_write, PMADMUX};
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: sample outputs mid-cycle, then advance one clock.
    task automatic tick(input logic [12:0] exp, input string nm);
        #1;
        chk(nm, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string nm);
        chk({nm, "_hit"},  32'(hit_count),  32'(m_hit));
        chk({nm, "_miss"}, 32'(miss_count), 32'(m_miss));
        chk({nm, "_wb"},   32'(wb_count),   32'(m_wb));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        SIGHIT = 1'b0; SIGDIRTY = 1'b0; clr_counters = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        @(posedge clk);
        #2;
        chk("rst_outs", 32'(outs()), 32'(O_NONE));
        chk_counters("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One CPU transaction with a reactive pmem responder; the expected
    // mem_resp cycle and counters follow from the hit/miss/dirty rules.
    task automatic run_txn(input logic rd, input logic wr, input logic hit,
                           input logic dirty, input int nw, input int nf);
        int  wc, fc, lat, exp_lat;
        bit  overlap;
        wc = 0; fc = 0; lat = 0; overlap = 1'b0;
        mem_read = rd; mem_write = wr; SIGDIRTY = dirty;
        for (int c = 1; c <= 40; c++) begin
            SIGHIT = (c == 2) ? hit : 1'b1;
            pmem_resp = 1'b0;
            #1;
            if (pmem_write) begin wc++; pmem_resp = (wc == nw); end
            if (pmem_read)  begin fc++; pmem_resp = (fc == nf); end
            #1;
            if (pmem_read && pmem_write) overlap = 1'b1;
            if (mem_resp) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0; SIGHIT = 1'b0;
        exp_lat = hit ? 2 : 4 + (dirty ? nw : 0) + nf;
        m_hit = sat(m_hit);
        if (!hit) begin
            m_miss = sat(m_miss);
            if (dirty) m_wb = sat(m_wb);
        end
        chk("txn_latency", 32'(lat), 32'(exp_lat));
        chk("txn_pmem_overlap", 32'(overlap), 32'd0);
        chk_counters("txn");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_RHIT, "vec_read_hit"};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_WHIT, "vec_write_hit"};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_WHIT, "vec_rdwr_hit"};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "vec_dropped"};

        do_reset();

        for (int i = 0; i < 4; i++) begin
            mem_read = vecs[i].rd1; mem_write = vecs[i].wr1; SIGHIT = vecs[i].hit;
            tick(O_NONE, {vecs[i].nm, "_idle"});
            mem_read = vecs[i].rd2; mem_write = vecs[i].wr2;
            tick(vecs[i].exp, vecs[i].nm);
            mem_read = 1'b0; mem_write = 1'b0;
            tick(O_NONE, {vecs[i].nm, "_after"});
        end

        // Clean read miss with a three-cycle fill.
        do_reset();
        mem_read = 1'b1; SIGHIT = 1'b0; SIGDIRTY = 1'b0;
        tick(O_NONE, "cm_idle");
        tick(O_NONE, "cm_compare");
        tick(O_ALLOC, "cm_alloc1");
        tick(O_ALLOC, "cm_alloc2");
        pmem_resp = 1'b1;
        tick(O_FILL, "cm_fill");
        pmem_resp = 1'b0;
        tick(O_NONE, "cm_refill");
        SIGHIT = 1'b1;
        tick(O_RHIT, "cm_hit");
        mem_read = 1'b0;
        m_hit = 1; m_miss = 1; m_wb = 0;
        chk_counters("cm");

        // Dirty write miss: writeback, then fill, then merge on the re-compare.
        do_reset();
        mem_write = 1'b1; SIGHIT = 1'b0; SIGDIRTY = 1'b1;
        tick(O_NONE, "dm_idle");
        tick(O_NONE, "dm_compare");
        tick(O_WB, "dm_wb1");
        pmem_resp = 1'b1;
        tick(O_WBDONE, "dm_wbdone");
        tick(O_FILL, "dm_fill");
        pmem_resp = 1'b0;
        tick(O_NONE, "dm_refill");
        SIGHIT = 1'b1;
        tick(O_WHIT, "dm_merge");
        mem_write = 1'b0;
        m_hit = 1; m_miss = 1; m_wb = 1;
        chk_counters("dm");

        // Async reset in the middle of a fill, then a stray pmem_resp.
        do_reset();
        mem_read = 1'b1; SIGHIT = 1'b0; SIGDIRTY = 1'b0;
        tick(O_NONE, "ar_idle");
        tick(O_NONE, "ar_compare");
        #1;
        chk("ar_alloc", 32'(outs()), 32'(O_ALLOC));
        #1;
        rst = 1'b1;
        #1;
        chk("ar_pmem_read_drop", 32'(pmem_read), 32'd0);
        chk("ar_outs_in_reset", 32'(outs()), 32'(O_NONE));
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pmem_resp = 1'b1;
        tick(O_NONE, "ar_stray1");
        tick(O_NONE, "ar_stray2");
        pmem_resp = 1'b0;
        mem_read = 1'b1; SIGHIT = 1'b1;
        tick(O_NONE, "ar_req_idle");
        tick(O_RHIT, "ar_hit");
        mem_read = 1'b0;
        m_hit = 1; m_miss = 0; m_wb = 0;
        chk_counters("ar");

        // Clear coinciding with a hit leaves the counter at zero.
        mem_read = 1'b1; SIGHIT = 1'b1;
        tick(O_NONE, "clr_idle");
        clr_counters = 1'b1;
        tick(O_RHIT, "clr_hit");
        clr_counters = 1'b0; mem_read = 1'b0;
        chk("clr_hit_count", 32'(hit_count), 32'd0);
        m_hit = 0; m_miss = 0; m_wb = 0;

        // Drive miss_count past all-ones.
        for (int i = 0; i < 17; i++) begin
            run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
        end
        chk("sat_miss_count", 32'(miss_count), 32'(CMAX));

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            int k;
            logic rd, wr;
            k = $urandom_range(0, 2);
            rd = (k != 1);
            wr = (k != 0);
            if ($urandom_range(0, 3) == 0) clr_counters = 1'b1;
            if (clr_counters) begin
                tick(O_NONE, "rnd_clr");
                clr_counters = 1'b0;
                m_hit = 0; m_miss = 0; m_wb = 0;
            end
            run_txn(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 4), $urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
